// File: rtl/sim_seq_pkg.sv
// Shared types and defaults for the simulation-run sequencer.
// Holds the state encoding, default parameter values and the dump-window compare.
package sim_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RST_HOLD = 3'd1,
      ST_RUN      = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_DONE     = 3'd4
   } seq_state_t;

   localparam int DEF_CYC_W        = 8;
   localparam int DEF_RST_CYCLES   = 2;
   localparam int DEF_RUN_CYCLES   = 15;
   localparam int DEF_DRAIN_CYCLES = 2;
   localparam int DEF_DUMP_START   = 0;
   localparam int DEF_DUMP_STOP    = 15;

   // Half-open window [lo, hi): the stop value is the first count with the dump closed.
   function automatic logic in_dump_window(input int unsigned cyc,
                                           input int unsigned lo,
                                           input int unsigned hi);
      return (cyc >= lo) && (cyc < hi);
   endfunction

endpackage

// File: rtl/sim_phase_timer.sv
// Loadable down-counter used to time the reset-hold and drain phases.
// Load has priority over decrement; the count stops at zero.
module sim_phase_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/sim_run_sequencer.sv
// Controller that holds a DUT in reset, runs it for a bounded cycle count,
// gates the dump window, drains and pulses finish. All outputs are registered.
module sim_run_sequencer
   import sim_seq_pkg::*;
#(
   parameter int CYC_W        = DEF_CYC_W,
   parameter int RST_CYCLES   = DEF_RST_CYCLES,
   parameter int RUN_CYCLES   = DEF_RUN_CYCLES,
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter int DUMP_START   = DEF_DUMP_START,
   parameter int DUMP_STOP    = DEF_DUMP_STOP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   output logic             dut_rst,
   output logic             run_en,
   output logic [CYC_W-1:0] cycle,
   output logic             dump_en,
   output logic             finish,
   output logic             done,
   output logic             aborted,
   output logic             busy
);

   localparam int TMR_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
   localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

   localparam logic [TMR_W-1:0] RST_LOAD   = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
   localparam logic [CYC_W-1:0] LAST_CYC   = CYC_W'(RUN_CYCLES - 1);

   if (RST_CYCLES < 1) begin : g_bad_rst
      $fatal(1, "sim_run_sequencer: RST_CYCLES must be >= 1");
   end
   if ((RUN_CYCLES < 1) || (RUN_CYCLES > (1 << CYC_W) - 1)) begin : g_bad_run
      $fatal(1, "sim_run_sequencer: RUN_CYCLES out of range for CYC_W");
   end
   if (DRAIN_CYCLES < 0) begin : g_bad_drain
      $fatal(1, "sim_run_sequencer: DRAIN_CYCLES must be >= 0");
   end
   if ((DUMP_START < 0) || (DUMP_START > DUMP_STOP) || (DUMP_STOP > RUN_CYCLES)) begin : g_bad_dump
      $fatal(1, "sim_run_sequencer: need 0 <= DUMP_START <= DUMP_STOP <= RUN_CYCLES");
   end

   seq_state_t       state, next_state;
   logic [CYC_W-1:0] next_cycle;
   logic             next_finish, next_done, next_aborted;
   logic             next_dut_rst, next_run_en, next_dump_en, next_busy;
   logic             tmr_load, tmr_en, tmr_zero;
   logic [TMR_W-1:0] tmr_load_val;

   sim_phase_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cycle   <= '0;
         dut_rst <= 1'b1;
         run_en  <= 1'b0;
         dump_en <= 1'b0;
         finish  <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= next_state;
         cycle   <= next_cycle;
         dut_rst <= next_dut_rst;
         run_en  <= next_run_en;
         dump_en <= next_dump_en;
         finish  <= next_finish;
         done    <= next_done;
         aborted <= next_aborted;
         busy    <= next_busy;
      end
   end

   // Abort outranks pause, the phase timer and the terminal count in every active state.
   always_comb begin
      next_state   = state;
      next_cycle   = cycle;
      next_finish  = 1'b0;
      next_done    = done;
      next_aborted = aborted;
      tmr_load     = 1'b0;
      tmr_load_val = RST_LOAD;
      tmr_en       = 1'b0;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               next_state   = ST_RST_HOLD;
               next_cycle   = '0;
               next_done    = 1'b0;
               next_aborted = 1'b0;
               tmr_load     = 1'b1;
               tmr_load_val = RST_LOAD;
            end
         end
         ST_RST_HOLD: begin
            if (abort) begin
               next_state   = ST_DONE;
               next_finish  = 1'b1;
               next_done    = 1'b1;
               next_aborted = 1'b1;
            end else if (tmr_zero) begin
               next_state = ST_RUN;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort) begin
               next_state   = ST_DONE;
               next_finish  = 1'b1;
               next_done    = 1'b1;
               next_aborted = 1'b1;
            end else if (!pause) begin
               next_cycle = cycle + 1'b1;
               if (cycle == LAST_CYC) begin
                  if (DRAIN_CYCLES == 0) begin
                     next_state  = ST_DONE;
                     next_finish = 1'b1;
                     next_done   = 1'b1;
                  end else begin
                     next_state   = ST_DRAIN;
                     tmr_load     = 1'b1;
                     tmr_load_val = DRAIN_LOAD;
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               next_state   = ST_DONE;
               next_finish  = 1'b1;
               next_done    = 1'b1;
               next_aborted = 1'b1;
            end else if (tmr_zero) begin
               next_state  = ST_DONE;
               next_finish = 1'b1;
               next_done   = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Outputs are derived from the next state so the registered values line up with state.
   always_comb begin
      next_dut_rst = (next_state == ST_IDLE) || (next_state == ST_RST_HOLD);
      next_run_en  = (next_state == ST_RUN) && !pause;
      next_dump_en = (next_state == ST_RUN) &&
                     in_dump_window(32'(next_cycle), DUMP_START, DUMP_STOP);
      next_busy    = (next_state == ST_RST_HOLD) || (next_state == ST_RUN) ||
                     (next_state == ST_DRAIN);
   end

endmodule
